// File: rtl/serial_image_loader.sv
// Serial bootloader receiver: synchronises host clock/data pins, parses a
// length header, data words and optional checksum, and writes words to ROM.
module serial_image_loader #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          CHECKSUM_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  data_clk,
  input  logic                  data_pin,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned SHIFT_W = (WORD_WIDTH - 1 > ADDR_WIDTH) ? WORD_WIDTH - 1 : ADDR_WIDTH;
  localparam int unsigned GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BCNT_W  = $clog2(WORD_WIDTH + LEN_W);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_FIN} state_e;

  logic [SYNC_STAGES-1:0] dclk_sync_q, pin_sync_q;
  logic                   dclk_prev_q;
  logic                   bit_v_c, din_c;

  state_e                 state_q, state_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [WORD_WIDTH-1:0]  sum_q, sum_d;
  logic [LEN_W-1:0]       wcnt_q, wcnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   in_frame_c, timeout_c;
  logic [LEN_W-1:0]       len_c, wcnt_inc_c;
  logic [WORD_WIDTH-1:0]  word_c;

  // Pin synchronisers and rising-edge detect on the host clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dclk_sync_q <= '0;
      pin_sync_q  <= '0;
      dclk_prev_q <= 1'b0;
    end else begin
      dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], data_clk};
      pin_sync_q  <= {pin_sync_q[SYNC_STAGES-2:0], data_pin};
      dclk_prev_q <= dclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign bit_v_c = enable && dclk_sync_q[SYNC_STAGES-1] && !dclk_prev_q;
  assign din_c   = pin_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bcnt_q    <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      wcnt_q    <= '0;
      gap_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wcnt_q    <= wcnt_d;
      gap_q     <= gap_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Frame parser; done/error are set on the transition so they rise one
  // cycle after the final bit is sampled
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    len_d      = len_q;
    sum_d      = sum_q;
    wcnt_d     = wcnt_q;
    gap_d      = gap_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    in_frame_c = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    timeout_c  = in_frame_c && (gap_q >= GAP_W'(TIMEOUT_CYCLES));
    len_c      = {shift_q[ADDR_WIDTH-1:0], din_c};
    word_c     = {shift_q[WORD_WIDTH-2:0], din_c};
    wcnt_inc_c = wcnt_q + LEN_W'(1);

    if (!in_frame_c || bit_v_c) gap_d = '0;
    else if (!timeout_c)        gap_d = gap_q + GAP_W'(1);

    if (bit_v_c) shift_d = {shift_q[SHIFT_W-2:0], din_c};

    if (in_frame_c && !enable) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (timeout_c) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bit_v_c) begin
            state_d = S_LEN;
            bcnt_d  = BCNT_W'(1);
            sum_d   = '0;
            wcnt_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
          end
        end
        S_LEN: begin
          if (bit_v_c) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(ADDR_WIDTH)) begin
              bcnt_d = '0;
              len_d  = len_c;
              if (len_c == '0) begin
                if (CHECKSUM_EN) begin
                  state_d = S_CSUM;
                end else begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                end
              end else if (len_c[ADDR_WIDTH] && (|len_c[ADDR_WIDTH-1:0])) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                error_d = 1'b1;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (bit_v_c) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(WORD_WIDTH - 1)) begin
              bcnt_d    = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = wcnt_q[ADDR_WIDTH-1:0];
              wr_data_d = word_c;
              sum_d     = sum_q + word_c;
              wcnt_d    = wcnt_inc_c;
              if (wcnt_inc_c == len_q) begin
                if (CHECKSUM_EN) begin
                  state_d = S_CSUM;
                end else begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                end
              end
            end
          end
        end
        S_CSUM: begin
          if (bit_v_c) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(WORD_WIDTH - 1)) begin
              bcnt_d = '0;
              busy_d = 1'b0;
              if (word_c == sum_q) begin
                state_d = S_FIN;
                done_d  = 1'b1;
              end else begin
                state_d = S_IDLE;
                error_d = 1'b1;
              end
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_serial_image_loader.sv
// Randomised scoreboard bench: a frame-level model queues expected writes and
// end-of-frame status; a negedge monitor pops and compares DUT events.
module tb_serial_image_loader;

  localparam int unsigned HALF = 6;
  localparam int unsigned TMO  = 200;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit          done;
    bit          err;
    int unsigned wc;
    bit          lat;
  } st_t;

  logic clk = 1'b0;
  logic reset, en, dclk, dpin;
  bit   sel;

  logic        wr_en_a, busy_a, done_a, error_a;
  logic [3:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [4:0]  wc_a;
  logic        wr_en_b, busy_b, done_b, error_b;
  logic [2:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [3:0]  wc_b;

  int cyc = 0;
  int rise_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit pb_a = 1'b0;
  bit pb_b = 1'b0;

  wr_t exp_wr_a[$];
  wr_t exp_wr_b[$];
  st_t exp_st_a[$];
  st_t exp_st_b[$];
  logic [31:0] fw[$];

  serial_image_loader #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .SYNC_STAGES(2),
                        .TIMEOUT_CYCLES(TMO), .CHECKSUM_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .enable(en & ~sel), .data_clk(dclk), .data_pin(dpin),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a),
    .done(done_a), .error(error_a), .word_count(wc_a));

  serial_image_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(3), .SYNC_STAGES(3),
                        .TIMEOUT_CYCLES(TMO), .CHECKSUM_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .enable(en & sel), .data_clk(dclk), .data_pin(dpin),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
    .done(done_b), .error(error_b), .word_count(wc_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input bit w, input bit wen, input int unsigned addr, input logic [31:0] data,
                     input bit bsy, input bit dn, input bit er, input int unsigned wc);
    wr_t ew;
    st_t es;
    bit  pb;
    int  lat;
    lat = w ? 4 : 3;
    pb  = w ? pb_b : pb_a;
    if (wen) begin
      if ((w ? exp_wr_b.size() : exp_wr_a.size()) == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write dut=%0d: actual addr=%0d data=0x%0h required none", w, addr, data);
      end else begin
        ew = w ? exp_wr_b.pop_front() : exp_wr_a.pop_front();
        chk(w ? "wr_addr_b" : "wr_addr_a", 64'(addr), 64'(ew.addr));
        chk(w ? "wr_data_b" : "wr_data_a", 64'(data), 64'(ew.data));
        chk(w ? "wr_lat_b" : "wr_lat_a", 64'(cyc - rise_cyc), 64'(lat));
      end
    end
    if (pb && !bsy) begin
      if ((w ? exp_st_b.size() : exp_st_a.size()) == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_end dut=%0d: actual done=%0d error=%0d required none", w, dn, er);
      end else begin
        es = w ? exp_st_b.pop_front() : exp_st_a.pop_front();
        chk(w ? "done_b" : "done_a", 64'(dn), 64'(es.done));
        chk(w ? "error_b" : "error_a", 64'(er), 64'(es.err));
        chk(w ? "word_count_b" : "word_count_a", 64'(wc), 64'(es.wc));
        if (es.lat) chk(w ? "end_lat_b" : "end_lat_a", 64'(cyc - rise_cyc), 64'(lat));
      end
    end
    if (w) pb_b = bsy; else pb_a = bsy;
  endtask

  always @(negedge clk) begin
    mon(1'b0, wr_en_a, 32'(wr_addr_a), wr_data_a, busy_a, done_a, error_a, 32'(wc_a));
    mon(1'b1, wr_en_b, 32'(wr_addr_b), 32'(wr_data_b), busy_b, done_b, error_b, 32'(wc_b));
  end

  task automatic push_wr(input bit w, input int unsigned a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    if (w) exp_wr_b.push_back(e); else exp_wr_a.push_back(e);
  endtask

  task automatic push_st(input bit w, input bit dn, input bit er, input int unsigned wc, input bit lat);
    st_t s;
    s.done = dn; s.err = er; s.wc = wc; s.lat = lat;
    if (w) exp_st_b.push_back(s); else exp_st_a.push_back(s);
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    dpin = b;
    @(negedge clk);
    dclk = 1'b1;
    rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
    dclk = 1'b0;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic rand_words(input int n);
    fw.delete();
    repeat (n) fw.push_back($urandom);
  endtask

  // Model: expected writes and status derived from the frame contents, then bits sent
  task automatic send_frame(input bit w, input int n, input bit bad, input int stall_at);
    int          aw, ww, k;
    logic [31:0] mask, sum, cs, d;
    aw   = w ? 3 : 4;
    ww   = w ? 16 : 32;
    mask = w ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    sum  = '0;
    sel  = w;
    if (n > (1 << aw)) begin
      push_st(w, 1'b0, 1'b1, 0, 1'b1);
      send_bits(64'(n), aw + 1);
      repeat (4) @(negedge clk);
      return;
    end
    for (int i = 0; i < n; i++) begin
      push_wr(w, i, fw[i] & mask);
      sum = (sum + (fw[i] & mask)) & mask;
    end
    cs = (sum + 32'(bad)) & mask;
    if (w) push_st(w, 1'b1, 1'b0, n, 1'b1);
    else   push_st(w, !bad, bad, n, 1'b1);
    send_bits(64'(n), aw + 1);
    k = 0;
    for (int i = 0; i < n; i++) begin
      d = fw[i];
      for (int b = ww - 1; b >= 0; b--) begin
        if (k == stall_at) repeat (TMO - 50) @(negedge clk);
        send_bit(d[b]);
        k++;
      end
    end
    if (!w) send_bits(64'(cs), ww);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b0; en = 1'b0; dclk = 1'b0; dpin = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", 64'({wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, error_a, wc_a}), 64'd0);
    chk("reset_outputs_b", 64'({wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b, error_b, wc_b}), 64'd0);
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);

    fw = '{32'h0000_0013, 32'h0010_0093, 32'hFFFF_FFFF};
    send_frame(1'b0, 3, 1'b0, -1);
    send_frame(1'b0, 3, 1'b1, -1);

    // Header N=2 plus 10 bits, then stall past the timeout
    sel = 1'b0;
    push_st(1'b0, 1'b0, 1'b1, 0, 1'b0);
    send_bits(64'd2, 5);
    send_bits(64'($urandom), 10);
    repeat (TMO + 60) @(negedge clk);
    fw = '{32'hDEAD_BEEF};
    send_frame(1'b0, 1, 1'b0, -1);

    send_frame(1'b0, 0, 1'b0, -1);

    // Host clock toggling with loading disabled must leave status untouched
    en = 1'b0;
    send_bits(64'($urandom), 20);
    chk("en_off_busy", 64'(busy_a), 64'd0);
    chk("en_off_done", 64'(done_a), 64'd1);
    chk("en_off_error", 64'(error_a), 64'd0);
    en = 1'b1;

    send_frame(1'b0, 17, 1'b0, -1);
    rand_words(16);
    send_frame(1'b0, 16, 1'b0, -1);

    // Enable dropped mid-word after one complete word
    rand_words(2);
    push_wr(1'b0, 0, fw[0]);
    push_st(1'b0, 1'b0, 1'b0, 1, 1'b0);
    send_bits(64'd2, 5);
    send_bits(64'(fw[0]), 32);
    send_bits(64'h15, 5);
    en = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 4));
      rand_words(n);
      send_frame(1'b0, n, ($urandom % 4) == 0,
                 ($urandom % 2) != 0 ? int'($urandom_range(0, n * 32 - 1)) : -1);
    end

    fw = '{32'h1234, 32'hABCD};
    send_frame(1'b1, 2, 1'b0, -1);
    rand_words(8);
    send_frame(1'b1, 8, 1'b0, -1);
    send_frame(1'b1, 9, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 4));
      rand_words(n);
      send_frame(1'b1, n, 1'b0, -1);
    end

    // Reset asserted in the middle of word 1
    sel = 1'b0;
    rand_words(3);
    push_wr(1'b0, 0, fw[0]);
    push_st(1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_bits(64'd3, 5);
    send_bits(64'(fw[0]), 32);
    send_bits(64'hA5, 8);
    #2 reset = 1'b0;
    #1 chk("mid_reset_outputs_a", 64'({wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, error_a, wc_a}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    fw = '{32'hCAFE_F00D};
    send_frame(1'b0, 1, 1'b0, -1);

    repeat (10) @(negedge clk);
    chk("pending_writes_a", 64'(exp_wr_a.size()), 64'd0);
    chk("pending_status_a", 64'(exp_st_a.size()), 64'd0);
    chk("pending_writes_b", 64'(exp_wr_b.size()), 64'd0);
    chk("pending_status_b", 64'(exp_st_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
